// File: rtl/crc32_stream_engine.sv
// crc32_stream_engine
//   Streaming Ethernet CRC-32 (FCS) engine. It accepts DATA_BYTES bytes per beat
//   over a valid/ready input and frames the work with start_port and done_port.
//   It also reports the frame length and, as an option, an RX residue check.
//
//   Optional feature: define CRC32_STREAM_CHECK_EN to add the fcs_ok output and
//   the residue comparator. With the macro undefined the build is complete, but
//   it has no fcs_ok port.
//
//   Handshake: a beat transfers on a rising clock edge when in_valid && in_ready.
//   in_ready depends only on the FSM state and start_port, never on in_valid.
//   in_ready is 1 only in RUN and only when start_port is low. A beat that is
//   offered in any other cycle is not consumed, and the source keeps it.
//
//   dbg_state shows the FSM state, so that external checkers can observe it.

module crc32_stream_engine #(
  parameter int          DATA_BYTES = 1,
  parameter logic [31:0] INIT       = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT    = 32'hFFFFFFFF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start_port,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic [DATA_BYTES-1:0]   in_keep,
  input  logic                    in_last,
  output logic                    done_port,
  output logic [31:0]             return_port,
  output logic [15:0]             length_port,
  output logic                    busy,
`ifdef CRC32_STREAM_CHECK_EN
  output logic                    fcs_ok,
`endif
  output logic [1:0]              dbg_state
);

  // Reflected form of polynomial 0x04C11DB7.
  localparam logic [31:0] POLY_REFL = 32'hEDB88320;
  // Raw register value that remains after an intact frame plus its FCS.
  localparam logic [31:0] RESIDUE   = 32'hDEBB20E3;

  if (!(DATA_BYTES == 1 || DATA_BYTES == 2 || DATA_BYTES == 4 || DATA_BYTES == 8)) begin : g_bad_width
    $error("crc32_stream_engine: DATA_BYTES must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] len_q, len_d;
  logic [31:0] ret_q;
  logic [15:0] len_out_q;
  logic        ld_result;

  logic [31:0] crc_beat;
  logic [4:0]  cnt_beat;
  logic [16:0] len_sum;
  logic [15:0] len_sat;
  logic        run_ok;

  // Folds one byte into a reflected CRC register. Bit 0 is the first serial bit.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ POLY_REFL) : (r >> 1);
    end
    return r;
  endfunction

  // Per-beat data path. Bytes are folded in order 0..DATA_BYTES-1. On a last
  // beat, folding stops at the first cleared keep bit.
  always_comb begin
    crc_beat = crc_q;
    cnt_beat = 5'd0;
    run_ok   = 1'b1;
    for (int i = 0; i < DATA_BYTES; i++) begin
      run_ok = run_ok & (~in_last | in_keep[i]);
      if (run_ok) begin
        crc_beat = crc_byte(crc_beat, in_data[8*i +: 8]);
        cnt_beat = cnt_beat + 5'd1;
      end
    end
  end

  // Frame length accumulator. It saturates at 16'hFFFF and does not wrap.
  always_comb begin
    len_sum = {1'b0, len_q} + {12'd0, cnt_beat};
    len_sat = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  end

  // FSM next state, handshake and register updates.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    in_ready  = 1'b0;
    done_port = 1'b0;
    ld_result = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_port) begin
          state_d = S_RUN;
          crc_d   = INIT;
          len_d   = 16'd0;
        end
      end
      S_RUN: begin
        if (start_port) begin
          // Abort: restart the frame. Any beat offered in this cycle is refused.
          crc_d = INIT;
          len_d = 16'd0;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            crc_d = crc_beat;
            len_d = len_sat;
            if (in_last) begin
              state_d   = S_DONE;
              ld_result = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        done_port = 1'b1;
        if (start_port) begin
          state_d = S_RUN;
          crc_d   = INIT;
          len_d   = 16'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, CRC register and length register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      crc_q   <= INIT;
      len_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
    end
  end

  // Result registers. They load on the last-beat handshake, so the result is
  // ready in the DONE cycle, and they hold until the next frame completes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ret_q     <= 32'd0;
      len_out_q <= 16'd0;
    end else if (ld_result) begin
      ret_q     <= crc_beat ^ XOR_OUT;
      len_out_q <= len_sat;
    end
  end

`ifdef CRC32_STREAM_CHECK_EN
  logic fcs_q;

  // Residue check on the raw register, taken with the result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fcs_q <= 1'b0;
    end else if (ld_result) begin
      fcs_q <= (crc_beat == RESIDUE);
    end
  end

  assign fcs_ok = fcs_q;
`endif

  assign return_port = ret_q;
  assign length_port = len_out_q;
  assign busy        = (state_q == S_RUN) || (state_q == S_DONE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_crc32_stream_engine.sv
// tb_crc32_stream_engine
//   Directed bench with two engines: one with DATA_BYTES=1 and one with DATA_BYTES=4.
//   Drivers push the hand-computed result of each frame into a per-engine
//   queue. Monitors pop from the queue and compare whenever done_port pulses.

module tb_crc32_stream_engine;

  typedef logic [7:0] bytes_t[$];

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic        s1, v1, r1, l1, d1, b1, f1;
  logic [7:0]  dat1;
  logic [0:0]  k1;
  logic [31:0] ret1;
  logic [15:0] len1;
  logic [1:0]  st1;

  logic        s4, v4, r4, l4, d4, b4, f4;
  logic [31:0] dat4;
  logic [3:0]  k4;
  logic [31:0] ret4;
  logic [15:0] len4;
  logic [1:0]  st4;

  crc32_stream_engine #(.DATA_BYTES(1)) u_dut1 (
    .clock(clock), .reset(reset), .start_port(s1), .in_valid(v1), .in_ready(r1),
    .in_data(dat1), .in_keep(k1), .in_last(l1), .done_port(d1), .return_port(ret1),
    .length_port(len1), .busy(b1),
`ifdef CRC32_STREAM_CHECK_EN
    .fcs_ok(f1),
`endif
    .dbg_state(st1)
  );

  crc32_stream_engine #(.DATA_BYTES(4)) u_dut4 (
    .clock(clock), .reset(reset), .start_port(s4), .in_valid(v4), .in_ready(r4),
    .in_data(dat4), .in_keep(k4), .in_last(l4), .done_port(d4), .return_port(ret4),
    .length_port(len4), .busy(b4),
`ifdef CRC32_STREAM_CHECK_EN
    .fcs_ok(f4),
`endif
    .dbg_state(st4)
  );

`ifndef CRC32_STREAM_CHECK_EN
  assign f1 = 1'b0;
  assign f4 = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  // Entry layout: {check_ret, fcs, len[15:0], ret[31:0]}
  int checks = 0;
  int errors = 0;
  logic [49:0] exp1_q[$];
  logic [49:0] exp4_q[$];
  logic [49:0] e1, e4;

  function automatic logic [49:0] mk(input logic chk, input logic fcs,
                                     input logic [15:0] len, input logic [31:0] ret);
    return {chk, fcs, len, ret};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_done(input string name, input logic [49:0] e, input logic [31:0] ret,
                            input logic [15:0] len, input logic fcs, input logic rdy,
                            input logic bsy);
    if (e[49]) chk({name, "_return"}, ret, e[31:0]);
    chk({name, "_length"}, 32'(len), 32'(e[47:32]));
    chk({name, "_ready_in_done"}, 32'(rdy), 32'd0);
    chk({name, "_busy_in_done"}, 32'(bsy), 32'd1);
`ifdef CRC32_STREAM_CHECK_EN
    chk({name, "_fcs_ok"}, 32'(fcs), 32'(e[48]));
`else
    if (fcs !== 1'b0) chk({name, "_fcs_tieoff"}, 32'(fcs), 32'd0);
`endif
  endtask

  // Monitor for the 1-byte engine.
  always @(negedge clock) begin
    if (reset === 1'b1 && d1 === 1'b1) begin
      if (exp1_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_done actual=1 required=0");
      end else begin
        e1 = exp1_q.pop_front();
        check_done("dut1", e1, ret1, len1, f1, r1, b1);
      end
    end
  end

  // Monitor for the 4-byte engine.
  always @(negedge clock) begin
    if (reset === 1'b1 && d4 === 1'b1) begin
      if (exp4_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut4_unexpected_done actual=1 required=0");
      end else begin
        e4 = exp4_q.pop_front();
        check_done("dut4", e4, ret4, len4, f4, r4, b4);
      end
    end
  end

  // ---------------- driver tasks (enter/leave at posedge+1) ----------------
  function automatic bytes_t to_bytes(input string s);
    bytes_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic pulse_start(input int sel);
    if (sel == 1) s1 = 1'b1; else s4 = 1'b1;
    @(posedge clock); #1;
    s1 = 1'b0; s4 = 1'b0;
  endtask

  task automatic beat(input int sel, input logic [31:0] data, input logic [3:0] keep,
                      input logic last, input bit gaps);
    logic rdy;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end
    if (sel == 1) begin v1 = 1'b1; dat1 = data[7:0]; k1 = keep[0:0]; l1 = last; end
    else          begin v4 = 1'b1; dat4 = data;      k4 = keep;      l4 = last; end
    for (int t = 0; t < 100; t++) begin
      @(negedge clock);
      rdy = (sel == 1) ? r1 : r4;
      @(posedge clock); #1;
      if (rdy) begin
        if (sel == 1) begin v1 = 1'b0; dat1 = 8'($urandom); k1 = 1'($urandom); l1 = 1'($urandom); end
        else          begin v4 = 1'b0; dat4 = $urandom; k4 = 4'($urandom); l4 = 1'($urandom); end
        return;
      end
    end
    checks++; errors++;
    $display("FAIL handshake_timeout_dut%0d actual=no_ready required=ready", sel);
    v1 = 1'b0; v4 = 1'b0;
  endtask

  task automatic send1(input bytes_t b, input bit last);
    for (int i = 0; i < b.size(); i++) begin
      if (last && i == b.size() - 1) beat(1, {24'd0, b[i]}, 4'h1, 1'b1, 1'b1);
      else                           beat(1, {24'd0, b[i]}, 4'($urandom), 1'b0, 1'b1);
    end
  endtask

  task automatic send4(input bytes_t b, input bit last);
    int n, rem, kk;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        is_last;
    n = b.size();
    for (int i = 0; i < n; i += 4) begin
      rem  = n - i;
      data = $urandom;
      for (int j = 0; j < 4; j++) if (j < rem) data[8*j +: 8] = b[i+j];
      is_last = last && (rem <= 4);
      kk   = (rem >= 4) ? 15 : ((1 << rem) - 1);
      keep = is_last ? kk[3:0] : 4'($urandom);
      beat(4, data, keep, is_last, 1'b1);
    end
  endtask

  task automatic wait_drain(input int sel);
    for (int t = 0; t < 40; t++) begin
      if ((sel == 1 ? exp1_q.size() : exp4_q.size()) == 0) return;
      @(posedge clock); #1;
    end
    checks++; errors++;
    $display("FAIL drain_timeout_dut%0d actual=no_done required=done", sel);
    if (sel == 1) exp1_q.delete(); else exp4_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_d1_ready"},  32'(r1),   32'd0);
    chk({tag, "_d1_done"},   32'(d1),   32'd0);
    chk({tag, "_d1_return"}, ret1,      32'd0);
    chk({tag, "_d1_length"}, 32'(len1), 32'd0);
    chk({tag, "_d1_busy"},   32'(b1),   32'd0);
    chk({tag, "_d4_ready"},  32'(r4),   32'd0);
    chk({tag, "_d4_done"},   32'(d4),   32'd0);
    chk({tag, "_d4_return"}, ret4,      32'd0);
    chk({tag, "_d4_length"}, 32'(len4), 32'd0);
    chk({tag, "_d4_busy"},   32'(b4),   32'd0);
`ifdef CRC32_STREAM_CHECK_EN
    chk({tag, "_d1_fcs"}, 32'(f1), 32'd0);
    chk({tag, "_d4_fcs"}, 32'(f4), 32'd0);
`endif
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  bytes_t fr;

  initial begin
    s1 = 0; v1 = 0; l1 = 0; dat1 = '0; k1 = '0;
    s4 = 0; v4 = 0; l4 = 0; dat4 = '0; k4 = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("por");
    reset = 1'b1;
    @(posedge clock); #1;

    // Check string on the 1-byte engine.
    pulse_start(1);
    exp1_q.push_back(mk(1'b1, 1'b0, 16'd9, 32'hCBF43926));
    send1(to_bytes("123456789"), 1'b1);
    wait_drain(1);

    // Check string on the 4-byte engine. The last beat is '9' with keep=0001.
    pulse_start(4);
    exp4_q.push_back(mk(1'b1, 1'b0, 16'd9, 32'hCBF43926));
    send4(to_bytes("123456789"), 1'b1);
    wait_drain(4);

    // Empty frame on both engines: last beat with keep=0.
    pulse_start(1);
    exp1_q.push_back(mk(1'b1, 1'b0, 16'd0, 32'h00000000));
    beat(1, $urandom, 4'h0, 1'b1, 1'b1);
    wait_drain(1);
    pulse_start(4);
    exp4_q.push_back(mk(1'b1, 1'b0, 16'd0, 32'h00000000));
    beat(4, $urandom, 4'h0, 1'b1, 1'b1);
    wait_drain(4);

    // Abort: restart after "ABC". A last beat offered with the restart must be refused.
    pulse_start(1);
    send1(to_bytes("ABC"), 1'b0);
    s1 = 1'b1; v1 = 1'b1; dat1 = 8'h55; k1 = 1'b1; l1 = 1'b1;
    @(posedge clock); #1;
    s1 = 1'b0; v1 = 1'b0; l1 = 1'b0;
    exp1_q.push_back(mk(1'b1, 1'b0, 16'd9, 32'hCBF43926));
    send1(to_bytes("123456789"), 1'b1);
    wait_drain(1);

    // start_port in DONE: "a" completes, then "abc" follows immediately.
    pulse_start(1);
    exp1_q.push_back(mk(1'b1, 1'b0, 16'd1, 32'hE8B7BE43));
    exp1_q.push_back(mk(1'b1, 1'b0, 16'd3, 32'h352441C2));
    send1(to_bytes("a"), 1'b1);
    pulse_start(1);
    send1(to_bytes("abc"), 1'b1);
    wait_drain(1);

    // Keep 0101 on a last beat: only byte 0 ("a") is used.
    pulse_start(4);
    exp4_q.push_back(mk(1'b1, 1'b0, 16'd1, 32'hE8B7BE43));
    beat(4, {8'h63, 8'h62, 8'h7A, 8'h61}, 4'b0101, 1'b1, 1'b1);
    wait_drain(4);

    // Three-byte last beat (keep=0111).
    pulse_start(4);
    exp4_q.push_back(mk(1'b1, 1'b0, 16'd3, 32'h352441C2));
    send4(to_bytes("abc"), 1'b1);
    wait_drain(4);

    // Good FCS: the residue gives return 0x2144DF1C and fcs_ok=1.
    fr = to_bytes("123456789");
    fr.push_back(8'h26); fr.push_back(8'h39); fr.push_back(8'hF4); fr.push_back(8'hCB);
    pulse_start(4);
    exp4_q.push_back(mk(1'b1, 1'b1, 16'd13, 32'h2144DF1C));
    send4(fr, 1'b1);
    wait_drain(4);
    pulse_start(1);
    exp1_q.push_back(mk(1'b1, 1'b1, 16'd13, 32'h2144DF1C));
    send1(fr, 1'b1);
    wait_drain(1);

    // One flipped bit: fcs_ok=0. The return value is not checked here.
    fr[3] = fr[3] ^ 8'h01;
    pulse_start(4);
    exp4_q.push_back(mk(1'b0, 1'b0, 16'd13, 32'h0));
    send4(fr, 1'b1);
    wait_drain(4);

    // Reset in the middle of a frame (DUT1 in RUN) drives all outputs low at once.
    pulse_start(1);
    send1(to_bytes("12345"), 1'b0);
    #3 reset = 1'b0;
    #1 check_reset_outputs("mid");
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    pulse_start(1);
    exp1_q.push_back(mk(1'b1, 1'b0, 16'd9, 32'hCBF43926));
    send1(to_bytes("123456789"), 1'b1);
    wait_drain(1);

    // Length saturation: 16400 full beats (65600 bytes) gives 16'hFFFF.
    pulse_start(4);
    exp4_q.push_back(mk(1'b0, 1'b0, 16'hFFFF, 32'h0));
    for (int i = 0; i < 16400; i++) begin
      beat(4, $urandom, 4'hF, (i == 16399), 1'b0);
    end
    wait_drain(4);

    repeat (4) @(posedge clock);
    #1;
    chk("final_queue_dut1", 32'(exp1_q.size()), 32'd0);
    chk("final_queue_dut4", 32'(exp4_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
